// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline stage with valid/ready, two-entry skid buffer, flush and stall counter
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WB_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic [DATA_W-1:0] ALUout_i,
  input  logic [DATA_W-1:0] MemWriteData_i,
  input  logic [ADDR_W-1:0] RegWriteAddr_i,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [1:0]        MEM_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] ALUout_o,
  output logic [DATA_W-1:0] MemWriteData_o,
  output logic [ADDR_W-1:0] RegWriteAddr_o,
  output logic [WB_W-1:0]   WB_o,
  output logic              MemWrite_o,
  output logic              MemRead_o,
  output logic              fwd_valid_o,
  output logic [ADDR_W-1:0] fwd_addr_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_main_alu, r_main_wd, r_skid_alu, r_skid_wd;
  logic [ADDR_W-1:0] r_main_ra, r_skid_ra;
  logic [WB_W-1:0]   r_main_wb, r_skid_wb;
  logic [1:0]        r_main_mem, r_skid_mem;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_acc;
  logic w_dep;

  // Handshake flags come from registered state only, so stall_i never reaches ready_o.
  assign valid_o = (r_state != S_EMPTY);
  assign ready_o = (r_state != S_FULL);
  assign w_acc   = valid_i & ready_o;
  assign w_dep   = valid_o & ~stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_EMPTY;
      r_main_alu  <= '0;
      r_main_wd   <= '0;
      r_main_ra   <= '0;
      r_main_wb   <= '0;
      r_main_mem  <= '0;
      r_skid_alu  <= '0;
      r_skid_wd   <= '0;
      r_skid_ra   <= '0;
      r_skid_wb   <= '0;
      r_skid_mem  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (valid_o && stall_i && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + 1'b1;

      if (flush_i) begin
        r_state <= S_EMPTY;
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_acc) begin
              r_state    <= S_ONE;
              r_main_alu <= ALUout_i;
              r_main_wd  <= MemWriteData_i;
              r_main_ra  <= RegWriteAddr_i;
              r_main_wb  <= WB_i;
              r_main_mem <= MEM_i;
            end
          end
          S_ONE: begin
            if (w_acc && w_dep) begin
              r_main_alu <= ALUout_i;
              r_main_wd  <= MemWriteData_i;
              r_main_ra  <= RegWriteAddr_i;
              r_main_wb  <= WB_i;
              r_main_mem <= MEM_i;
            end else if (w_acc) begin
              r_state    <= S_FULL;
              r_skid_alu <= ALUout_i;
              r_skid_wd  <= MemWriteData_i;
              r_skid_ra  <= RegWriteAddr_i;
              r_skid_wb  <= WB_i;
              r_skid_mem <= MEM_i;
            end else if (w_dep) begin
              r_state <= S_EMPTY;
            end
          end
          S_FULL: begin
            if (w_dep) begin
              r_state    <= S_ONE;
              r_main_alu <= r_skid_alu;
              r_main_wd  <= r_skid_wd;
              r_main_ra  <= r_skid_ra;
              r_main_wb  <= r_skid_wb;
              r_main_mem <= r_skid_mem;
            end
          end
          default: r_state <= S_EMPTY;
        endcase
      end
    end
  end

  // Control outputs are gated so a bubble never carries stale write enables.
  assign ALUout_o       = r_main_alu;
  assign MemWriteData_o = r_main_wd;
  assign RegWriteAddr_o = r_main_ra;
  assign WB_o           = valid_o ? r_main_wb : '0;
  assign MemWrite_o     = valid_o & r_main_mem[0];
  assign MemRead_o      = valid_o & r_main_mem[1];
  assign fwd_valid_o    = valid_o & WB_o[1];
  assign fwd_addr_o     = r_main_ra;
  assign stall_cnt_o    = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - randomized self-checking bench for ex_mem_pipe against a queue model
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst, valid_in, flush, stall;
  logic [31:0] alu_in, wd_in;
  logic [4:0]  ra_in;
  logic [1:0]  wb_in, mem_in;

  logic        ready_o, valid_o, mw_o, mr_o, fv_o;
  logic [31:0] alu_o, wd_o;
  logic [4:0]  ra_o, fa_o;
  logic [1:0]  wb_o;
  logic [15:0] cnt_o;

  logic        s_ready, s_valid, s_mw, s_mr, s_fv;
  logic [31:0] s_alu, s_wd;
  logic [4:0]  s_ra, s_fa;
  logic [1:0]  s_wb;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .ready_o(ready_o), .flush_i(flush), .stall_i(stall),
    .ALUout_i(alu_in), .MemWriteData_i(wd_in), .RegWriteAddr_i(ra_in), .WB_i(wb_in), .MEM_i(mem_in),
    .valid_o(valid_o), .ALUout_o(alu_o), .MemWriteData_o(wd_o), .RegWriteAddr_o(ra_o), .WB_o(wb_o),
    .MemWrite_o(mw_o), .MemRead_o(mr_o), .fwd_valid_o(fv_o), .fwd_addr_o(fa_o), .stall_cnt_o(cnt_o)
  );

  ex_mem_pipe #(.CNT_W(3)) dut_sat (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .ready_o(s_ready), .flush_i(flush), .stall_i(stall),
    .ALUout_i(alu_in), .MemWriteData_i(wd_in), .RegWriteAddr_i(ra_in), .WB_i(wb_in), .MEM_i(mem_in),
    .valid_o(s_valid), .ALUout_o(s_alu), .MemWriteData_o(s_wd), .RegWriteAddr_o(s_ra), .WB_o(s_wb),
    .MemWrite_o(s_mw), .MemRead_o(s_mr), .fwd_valid_o(s_fv), .fwd_addr_o(s_fa), .stall_cnt_o(s_cnt)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [1:0]  wb;
    logic [1:0]  mem;
  } item_t;

  // Reference: an in-order queue of at most two instructions plus an unbounded stall tally.
  item_t q[$];
  int    stall_cycles;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    item_t h;
    chk("valid_o", 64'(valid_o), 64'(q.size() > 0));
    chk("ready_o", 64'(ready_o), 64'(q.size() < 2));
    if (q.size() > 0) begin
      h = q[0];
      chk("ALUout_o", 64'(alu_o), 64'(h.alu));
      chk("MemWriteData_o", 64'(wd_o), 64'(h.wd));
      chk("RegWriteAddr_o", 64'(ra_o), 64'(h.ra));
      chk("WB_o", 64'(wb_o), 64'(h.wb));
      chk("MemWrite_o", 64'(mw_o), 64'(h.mem[0]));
      chk("MemRead_o", 64'(mr_o), 64'(h.mem[1]));
      chk("fwd_valid_o", 64'(fv_o), 64'(h.wb[1]));
      chk("fwd_addr_o", 64'(fa_o), 64'(h.ra));
    end else begin
      chk("bubble_WB_o", 64'(wb_o), 64'd0);
      chk("bubble_MemWrite_o", 64'(mw_o), 64'd0);
      chk("bubble_MemRead_o", 64'(mr_o), 64'd0);
      chk("bubble_fwd_valid_o", 64'(fv_o), 64'd0);
    end
    chk("stall_cnt_o", 64'(cnt_o), 64'((stall_cycles > 65535) ? 65535 : stall_cycles));
    chk("stall_cnt_sat", 64'(s_cnt), 64'((stall_cycles > 7) ? 7 : stall_cycles));
  endtask

  // Apply the model for the current inputs, clock once, then compare just after the edge.
  task automatic cycle();
    item_t it;
    bit    acc, dep;
    it = '{alu: alu_in, wd: wd_in, ra: ra_in, wb: wb_in, mem: mem_in};
    if (rst) begin
      q.delete();
      stall_cycles = 0;
    end else begin
      if (q.size() > 0 && stall) stall_cycles++;
      if (flush) begin
        q.delete();
      end else begin
        acc = valid_in && (q.size() < 2);
        dep = (q.size() > 0) && !stall;
        if (dep) void'(q.pop_front());
        if (acc) q.push_back(it);
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    rst = 0; valid_in = 0; flush = 0; stall = 0;
    alu_in = '0; wd_in = '0; ra_in = '0; wb_in = '0; mem_in = '0;
  endtask

  task automatic rand_payload();
    alu_in = $urandom; wd_in = $urandom;
    ra_in = 5'($urandom); wb_in = 2'($urandom); mem_in = 2'($urandom);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; valid_in = 1; rand_payload();
    cycle(); cycle();
    rst = 0; valid_in = 0;
  endtask

  initial begin
    stall_cycles = 0;
    idle_inputs();

    do_reset();
    chk("reset_valid_o", 64'(valid_o), 64'd0);
    chk("reset_ready_o", 64'(ready_o), 64'd1);
    chk("reset_ALUout_o", 64'(alu_o), 64'd0);
    chk("reset_stall_cnt", 64'(cnt_o), 64'd0);

    for (int i = 1; i <= 4; i++) begin
      valid_in = 1; rand_payload(); alu_in = 32'(i * 16);
      cycle();
      chk("stream_ALUout_o", 64'(alu_o), 64'(i * 16));
      chk("stream_ready_o", 64'(ready_o), 64'd1);
    end
    valid_in = 0; cycle();

    do_reset();
    valid_in = 1; rand_payload(); alu_in = 32'hA; cycle();
    stall = 1; alu_in = 32'hB; cycle();
    chk("skid_ready_drop", 64'(ready_o), 64'd0);
    alu_in = 32'hC; cycle(); cycle();
    chk("stall_hold_A", 64'(alu_o), 64'hA);
    chk("stall_cnt_3", 64'(cnt_o), 64'd3);
    stall = 0; cycle();
    chk("release_B", 64'(alu_o), 64'hB);
    cycle();
    chk("release_C", 64'(alu_o), 64'hC);
    valid_in = 0; cycle();
    chk("drained", 64'(valid_o), 64'd0);

    do_reset();
    valid_in = 1; rand_payload(); cycle();
    stall = 1; rand_payload(); cycle();
    flush = 1; mem_in = 2'b01; alu_in = 32'hDEAD; cycle();
    chk("flush_valid_o", 64'(valid_o), 64'd0);
    chk("flush_MemWrite_o", 64'(mw_o), 64'd0);
    chk("flush_ready_o", 64'(ready_o), 64'd1);
    flush = 0; stall = 0; valid_in = 0; cycle();
    chk("flush_no_ghost", 64'(valid_o), 64'd0);

    do_reset();
    wb_in = 2'b10; ra_in = 5'd7; valid_in = 0; cycle();
    chk("gate_fwd_valid0", 64'(fv_o), 64'd0);
    chk("gate_WB0", 64'(wb_o), 64'd0);
    valid_in = 1; cycle();
    chk("gate_fwd_valid1", 64'(fv_o), 64'd1);
    chk("gate_fwd_addr", 64'(fa_o), 64'd7);

    do_reset();
    valid_in = 1; rand_payload(); cycle();
    valid_in = 0; stall = 1;
    for (int i = 0; i < 10; i++) cycle();
    chk("sat_cnt_7", 64'(s_cnt), 64'd7);
    chk("wide_cnt_10", 64'(cnt_o), 64'd10);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      stall    = ($urandom_range(0, 2) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      rand_payload();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX/MEM pipeline stage with valid/ready flow control, a two-entry skid buffer, flush and a saturating stall counter. Sits between the EX stage (ALU result, store data, destination register, WB/MEM control) and the data-memory/cache stage. It holds its contents while the cache asserts stall, and never drops or duplicates an instruction. It converts invalid slots into bubbles whose control outputs are all zero.

## Interface
- DATA_W, 32, width of ALU result and store data
- ADDR_W, 5, width of register-file write address
- WB_W, 2, width of WB control field; bit 1 = RegWrite
- CNT_W, 16, width of stall-cycle counter
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  EX presents a valid instruction
- ready_o  out  1  stage can accept; registered, equals "skid entry empty"
- flush_i  in  1  discard all held instructions (branch/exception)
- stall_i  in  1  cache stall; downstream not accepting this cycle
- ALUout_i  in  DATA_W  ALU result / memory address
- MemWriteData_i  in  DATA_W  store data
- RegWriteAddr_i  in  ADDR_W  destination register
- WB_i  in  WB_W  write-back control
- MEM_i  in  2  bit 0 = MemWrite, bit 1 = MemRead
- valid_o  out  1  output slot holds a valid instruction
- ALUout_o, MemWriteData_o  out  DATA_W  payload of output slot
- RegWriteAddr_o  out  ADDR_W  payload of output slot
- WB_o  out  WB_W  WB control, forced 0 when !valid_o
- MemWrite_o, MemRead_o  out  1  MEM_i bits of output slot, forced 0 when !valid_o
- fwd_valid_o  out  1  valid_o & WB_o[1], for forwarding unit
- fwd_addr_o  out  ADDR_W  equals RegWriteAddr_o
- stall_cnt_o  out  CNT_W  cycles with valid_o & stall_i, saturating

## Operation
- Storage: main entry (drives outputs) and skid entry; state EMPTY, ONE, FULL.
- acc = valid_i & ready_o; dep = valid_o & !stall_i.
- EMPTY: acc -> ONE, main <= input.
- ONE: acc&dep -> ONE, main <= input. acc&!dep -> FULL, skid <= input. !acc&dep -> EMPTY. Neither -> hold.
- FULL: ready_o=0, so acc is impossible. dep -> ONE, main <= skid. Otherwise hold.
- valid_o = (state != EMPTY); ready_o = (state != FULL); both derive from registered state only.
- flush_i: next state EMPTY, input in the same cycle is discarded, and payload registers may keep stale data. Flush has priority over acc/dep. stall_cnt unaffected.
- Payload in main entry is stable while !dep, i.e. no change while stalled.
- Bubble gating: WB_o, MemWrite_o, MemRead_o and fwd_valid_o are 0 whenever valid_o=0, regardless of stale payload.
- stall_cnt increments by 1 on each cycle with valid_o & stall_i, sticks at 2^CNT_W-1, and is cleared only by reset.

## Timing
- Reset (rst_i=1 at a rising edge): state EMPTY, all payload registers 0, stall_cnt 0. After that edge valid_o=0, ready_o=1, and all data/control outputs are 0.
- Reset mid-operation discards both entries and takes priority over flush, acc and dep.
- Latency: input accepted at edge N appears on outputs after edge N if the stage was empty or draining, i.e. 1 cycle.
- Throughput: 1 instruction/cycle with stall_i=0.
- Stall onset: the instruction presented in the same cycle as the first stall is still accepted into skid, and ready_o drops the following cycle. There is no combinational path from stall_i to ready_o.
- Release: the first cycle with stall_i=0 drains main, skid moves to main, and ready_o returns 1 the next cycle.
- Simultaneous flush_i and stall_i: flush wins and the stage is EMPTY next cycle.

## Test plan
- Reset: hold rst_i 2 cycles with valid_i=1 -> valid_o=0, ready_o=1, WB_o=0, MemWrite_o=0, MemRead_o=0, stall_cnt_o=0.
- Streaming: 4 back-to-back inputs ALUout_i=0x10,0x20,0x30,0x40 with stall_i=0 -> the same values appear on ALUout_o on the 4 consecutive cycles that follow, 1-cycle latency, ready_o stays 1.
- Stall skid: stream A,B,C and assert stall_i for 3 cycles while A is on the outputs -> B is captured in skid, ready_o=0 for the stall, A is held stable, stall_cnt_o=3. After release the outputs show A, then B, then C, with none lost or duplicated.
- Flush: enter FULL (A on the outputs, B in skid), then assert flush_i together with valid_i=1, MEM_i=2'b01 -> next cycle valid_o=0, MemWrite_o=0, ready_o=1, and that input never appears.
- Bubble gating: WB_i=2'b10, RegWriteAddr_i=7, valid_i=0 -> fwd_valid_o=0 and WB_o=0. Repeat with valid_i=1 -> fwd_valid_o=1, fwd_addr_o=7.
- Counter saturation: CNT_W=3, hold a valid instruction with stall_i=1 for 10 cycles -> stall_cnt_o reaches 7 and stays at 7.
